// File: rtl/itof_pipe.sv
// itof_pipe: pipelined integer-to-binary32 converter.
//
// Accepts one signed or unsigned IN_WIDTH-bit integer per cycle under a
// valid/ready handshake. The result is rounded to nearest, ties to even, and
// an inexact flag is returned with it. An opaque tag travels with each operand.
//
// Pipeline: an operand transferred at edge N is held in the capture register.
// S1 (sign, magnitude and leading-one index) is registered at N+1. S2
// (normalise, guard/round/sticky and the RNE increment) is registered at N+2.
// S3 (exponent fix-up on mantissa carry, then pack) is registered at N+3 in
// the output register. A stall is global: when the output register is full
// and not taken, every stage holds.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_ready = ~stall
//   x, is_unsigned, tag_in operand, signedness select, opaque tag
//   out_valid/out_ready    output handshake
//   y, tag_out, inexact    binary32 result, its tag, rounding-happened flag
//   idle                   nothing in flight and no result pending
module itof_pipe #(
   parameter int IN_WIDTH  = 32,
   parameter int TAG_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  x,
   input  logic                 is_unsigned,
   input  logic [TAG_WIDTH-1:0] tag_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          y,
   output logic [TAG_WIDTH-1:0] tag_out,
   output logic                 inexact,
   output logic                 idle
);

   localparam int LW = $clog2(IN_WIDTH);
   // Magnitude plus room for 23 fraction bits, guard, and a bit below it.
   // This keeps the sticky field non-empty for every legal width.
   localparam int NW = IN_WIDTH + 25;

   // Capture register
   logic                 v0_q, v0_d;
   logic [IN_WIDTH-1:0]  x0_q, x0_d;
   logic                 uns0_q, uns0_d;
   logic [TAG_WIDTH-1:0] tag0_q, tag0_d;

   // S1 register
   logic                 v1_q, v1_d;
   logic                 sign1_q, sign1_d;
   logic [IN_WIDTH-1:0]  mag1_q, mag1_d;
   logic [LW-1:0]        lead1_q, lead1_d;
   logic [TAG_WIDTH-1:0] tag1_q, tag1_d;

   // S2 register
   logic                 v2_q, v2_d;
   logic                 sign2_q, sign2_d;
   logic                 zero2_q, zero2_d;
   logic [23:0]          mant2_q, mant2_d;
   logic [7:0]           exp2_q, exp2_d;
   logic                 inex2_q, inex2_d;
   logic [TAG_WIDTH-1:0] tag2_q, tag2_d;

   // S3 / output register
   logic                 out_valid_q, out_valid_d;
   logic [31:0]          y_q, y_d;
   logic [TAG_WIDTH-1:0] tag_out_q, tag_out_d;
   logic                 inexact_q, inexact_d;

   logic                 stall;

   // Stage datapath signals
   logic                 s1_sign;
   logic [IN_WIDTH-1:0]  s1_mag;
   logic [LW-1:0]        s1_lead;
   logic [LW-1:0]        s2_shamt;
   logic [NW-1:0]        s2_wide;
   logic [22:0]          s2_frac;
   logic                 s2_guard;
   logic                 s2_sticky;
   logic                 s2_rnd;
   logic                 s3_carry;
   logic [7:0]           s3_exp;
   logic [22:0]          s3_frac;
   logic [31:0]          s3_pack;

   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign tag_out   = tag_out_q;
   assign inexact   = inexact_q;
   assign idle      = ~(v0_q | v1_q | v2_q | out_valid_q);

   // S1: the negation is taken at IN_WIDTH bits and read as unsigned, so the
   // most negative input yields 2^(IN_WIDTH-1). The leading-one scan keeps
   // the highest set bit. A zero magnitude leaves index 0 and is detected later.
   always_comb begin
      s1_sign = ~uns0_q & x0_q[IN_WIDTH-1];
      s1_mag  = s1_sign ? -x0_q : x0_q;
      s1_lead = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (s1_mag[i]) s1_lead = LW'(i);
      end
   end

   // S2: the shift moves the leading one to the top of the wide vector. The
   // 23 bits below it form the fraction, the next bit is guard, and the rest
   // are sticky. A missing top bit after the shift means the operand was zero.
   always_comb begin
      s2_shamt  = LW'(IN_WIDTH - 1) - lead1_q;
      s2_wide   = {mag1_q, 25'd0} << s2_shamt;
      s2_frac   = s2_wide[NW-2 -: 23];
      s2_guard  = s2_wide[NW-25];
      s2_sticky = |s2_wide[NW-26:0];
      s2_rnd    = s2_guard & (s2_sticky | s2_frac[0]);
   end

   // S3: a carry out of the rounded fraction means the mantissa reached 2.0.
   // That result is 1.0 with the next exponent. Zero always packs as +0.
   always_comb begin
      s3_carry = mant2_q[23];
      s3_exp   = exp2_q + {7'd0, s3_carry};
      s3_frac  = s3_carry ? 23'd0 : mant2_q[22:0];
      s3_pack  = zero2_q ? 32'd0 : {sign2_q, s3_exp, s3_frac};
   end

   // Next-state: everything holds during a stall. Otherwise each valid bit
   // follows its predecessor, and payloads load only behind a valid bit. The
   // output fields therefore keep their last value when no result arrives.
   always_comb begin
      v0_d        = v0_q;
      x0_d        = x0_q;
      uns0_d      = uns0_q;
      tag0_d      = tag0_q;
      v1_d        = v1_q;
      sign1_d     = sign1_q;
      mag1_d      = mag1_q;
      lead1_d     = lead1_q;
      tag1_d      = tag1_q;
      v2_d        = v2_q;
      sign2_d     = sign2_q;
      zero2_d     = zero2_q;
      mant2_d     = mant2_q;
      exp2_d      = exp2_q;
      inex2_d     = inex2_q;
      tag2_d      = tag2_q;
      out_valid_d = out_valid_q;
      y_d         = y_q;
      tag_out_d   = tag_out_q;
      inexact_d   = inexact_q;
      if (!stall) begin
         v0_d = in_valid;
         if (in_valid) begin
            x0_d   = x;
            uns0_d = is_unsigned;
            tag0_d = tag_in;
         end
         v1_d = v0_q;
         if (v0_q) begin
            sign1_d = s1_sign;
            mag1_d  = s1_mag;
            lead1_d = s1_lead;
            tag1_d  = tag0_q;
         end
         v2_d = v1_q;
         if (v1_q) begin
            sign2_d = sign1_q;
            zero2_d = ~s2_wide[NW-1];
            mant2_d = {1'b0, s2_frac} + {23'd0, s2_rnd};
            exp2_d  = 8'd127 + 8'(lead1_q);
            inex2_d = s2_guard | s2_sticky;
            tag2_d  = tag1_q;
         end
         out_valid_d = v2_q;
         if (v2_q) begin
            y_d       = s3_pack;
            tag_out_d = tag2_q;
            inexact_d = inex2_q;
         end
      end
   end

   // State registers: reset empties every stage and clears the output fields.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v0_q        <= 1'b0;
         x0_q        <= '0;
         uns0_q      <= 1'b0;
         tag0_q      <= '0;
         v1_q        <= 1'b0;
         sign1_q     <= 1'b0;
         mag1_q      <= '0;
         lead1_q     <= '0;
         tag1_q      <= '0;
         v2_q        <= 1'b0;
         sign2_q     <= 1'b0;
         zero2_q     <= 1'b0;
         mant2_q     <= '0;
         exp2_q      <= '0;
         inex2_q     <= 1'b0;
         tag2_q      <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         tag_out_q   <= '0;
         inexact_q   <= 1'b0;
      end else begin
         v0_q        <= v0_d;
         x0_q        <= x0_d;
         uns0_q      <= uns0_d;
         tag0_q      <= tag0_d;
         v1_q        <= v1_d;
         sign1_q     <= sign1_d;
         mag1_q      <= mag1_d;
         lead1_q     <= lead1_d;
         tag1_q      <= tag1_d;
         v2_q        <= v2_d;
         sign2_q     <= sign2_d;
         zero2_q     <= zero2_d;
         mant2_q     <= mant2_d;
         exp2_q      <= exp2_d;
         inex2_q     <= inex2_d;
         tag2_q      <= tag2_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         tag_out_q   <= tag_out_d;
         inexact_q   <= inexact_d;
      end
   end

endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: self-checking bench for itof_pipe.
// The main instance is 32-bit. Two extra instances cover IN_WIDTH = 8 and 64.
// Expected results come from spec constants or from an arithmetic reference
// model (integer divide/modulo rounding).
module tb_itof_pipe;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid, in_ready, is_unsigned;
   logic [31:0] x;
   logic [4:0]  tag_in, tag_out;
   logic        out_valid, out_ready, inexact, idle;
   logic [31:0] y;

   logic        in_valid8, in_ready8, uns8, out_valid8, inexact8, idle8;
   logic [7:0]  x8;
   logic [4:0]  tag8, tag_out8;
   logic [31:0] y8;

   logic        in_valid64, in_ready64, uns64, out_valid64, inexact64, idle64;
   logic [63:0] x64;
   logic [4:0]  tag64, tag_out64;
   logic [31:0] y64;

   typedef struct packed {
      logic [31:0] y;
      logic [4:0]  tag;
      logic        inex;
      int unsigned cyc;
      int unsigned stalls;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned n_checks = 0, n_pass = 0;
   int unsigned cyc = 0, stall_cnt = 0, n_results = 0;
   logic        mon_stall;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_y;
   logic [4:0]  prev_tag;
   logic        prev_inex;
   logic [31:0] drv_y;
   logic        drv_inex;
   logic        done;
   int unsigned base;

   always #5 clk = ~clk;

   itof_pipe #(.IN_WIDTH(32), .TAG_WIDTH(5)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .is_unsigned(is_unsigned), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready), .y(y),
      .tag_out(tag_out), .inexact(inexact), .idle(idle)
   );

   itof_pipe #(.IN_WIDTH(8), .TAG_WIDTH(5)) dut8 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8),
      .x(x8), .is_unsigned(uns8), .tag_in(tag8),
      .out_valid(out_valid8), .out_ready(1'b1), .y(y8),
      .tag_out(tag_out8), .inexact(inexact8), .idle(idle8)
   );

   itof_pipe #(.IN_WIDTH(64), .TAG_WIDTH(5)) dut64 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid64), .in_ready(in_ready64),
      .x(x64), .is_unsigned(uns64), .tag_in(tag64),
      .out_valid(out_valid64), .out_ready(1'b1), .y(y64),
      .tag_out(tag_out64), .inexact(inexact64), .idle(idle64)
   );

   // Counts every comparison and reports each mismatch on one line.
   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, obs, expv);
   endtask

   // Reference: the magnitude is split into a kept 24-bit quotient and a
   // remainder. The remainder is compared with half a unit to decide rounding.
   function automatic void refConvert(input logic [63:0] xv, input int w, input bit uns,
                                      output logic [31:0] ry, output logic rinex);
      logic [64:0] full, xm65;
      logic [63:0] xm, mag, m, rem, unit;
      logic        s;
      int          p, e;
      full  = 65'd1 << w;
      xm65  = {1'b0, xv} & (full - 65'd1);
      xm    = xm65[63:0];
      s     = !uns && xm[w-1];
      mag   = s ? 64'(full - xm65) : xm;
      ry    = '0;
      rinex = 1'b0;
      rem   = '0;
      unit  = '0;
      if (mag == 0) return;
      p = 63;
      while (mag[p] == 1'b0) p--;
      if (p <= 23) begin
         m = mag << (23 - p);
      end else begin
         unit  = 64'd1 << (p - 23);
         m     = mag / unit;
         rem   = mag % unit;
         rinex = (rem != 0);
         if (rem > unit / 2 || (rem == unit / 2 && m[0])) m = m + 1;
      end
      e = 127 + p;
      if (m[24]) begin
         m = m >> 1;
         e++;
      end
      ry = {s, 8'(e), m[22:0]};
   endfunction

   // Presents one operand to the 32-bit instance, holding it until accepted.
   task automatic applyStimulus(input logic [31:0] xv, input logic uns, input logic [4:0] tg,
                                input logic [31:0] ey, input logic ei);
      logic acc;
      acc         = 1'b0;
      in_valid    = 1'b1;
      x           = xv;
      is_unsigned = uns;
      tag_in      = tg;
      drv_y       = ey;
      drv_inex    = ei;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) checkOutput("accept_timeout", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic drainAll(input string nm);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checkOutput(nm, exp_q.size(), 0);
   endtask

   // One isolated operation on the 8- or 64-bit instance.
   task automatic runSweep(input int w, input logic [63:0] xv, input bit uns,
                           input logic [31:0] ey, input logic ei, input string nm);
      logic       seen;
      logic [4:0] tg;
      seen = 1'b0;
      tg   = 5'(n_checks);
      if (w == 8) begin
         x8 = xv[7:0]; uns8 = uns; tag8 = tg; in_valid8 = 1'b1;
         checkOutput({nm, "_ready"}, in_ready8, 1);
      end else begin
         x64 = xv; uns64 = uns; tag64 = tg; in_valid64 = 1'b1;
         checkOutput({nm, "_ready"}, in_ready64, 1);
      end
      @(posedge clk);
      #1;
      in_valid8  = 1'b0;
      in_valid64 = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = (w == 8) ? out_valid8 : out_valid64;
      end
      checkOutput({nm, "_valid"}, seen, 1);
      if (seen) begin
         checkOutput({nm, "_y"},    (w == 8) ? y8 : y64, ey);
         checkOutput({nm, "_inex"}, (w == 8) ? inexact8 : inexact64, ei);
         checkOutput({nm, "_tag"},  (w == 8) ? tag_out8 : tag_out64, tg);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor on the falling edge. It checks in_ready and output stability
   // during stalls. It pops the scoreboard on output transfers, checking value
   // and latency (4 negedges plus one per stalled cycle). It pushes on accepts.
   always @(negedge clk) begin
      if (rstn) begin
         cyc++;
         mon_stall = out_valid && !out_ready;
         checkOutput("in_ready", in_ready, !mon_stall);
         if (prev_stall) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_y", y, prev_y);
            checkOutput("hold_tag", tag_out, prev_tag);
            checkOutput("hold_inex", inexact, prev_inex);
         end
         if (out_valid && out_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
               checkOutput("spurious_result", out_valid, 0);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("y", y, mon_e.y);
               checkOutput("tag", tag_out, mon_e.tag);
               checkOutput("inexact", inexact, mon_e.inex);
               checkOutput("latency", cyc - mon_e.cyc, 4 + stall_cnt - mon_e.stalls);
            end
         end
         if (in_valid && in_ready) begin
            mon_e.y      = drv_y;
            mon_e.tag    = tag_in;
            mon_e.inex   = drv_inex;
            mon_e.cyc    = cyc;
            mon_e.stalls = stall_cnt;
            exp_q.push_back(mon_e);
         end
         if (mon_stall) stall_cnt++;
         prev_stall = mon_stall;
         prev_y     = y;
         prev_tag   = tag_out;
         prev_inex  = inexact;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] xv, ry;
      logic [63:0] xw;
      logic        ri, uns;
      logic [31:0] corner [4];

      corner = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      rstn = 1'b0; in_valid = 1'b0; x = '0; is_unsigned = 1'b0; tag_in = '0;
      out_ready = 1'b1; drv_y = '0; drv_inex = 1'b0; done = 1'b0;
      in_valid8 = 1'b0; x8 = '0; uns8 = 1'b0; tag8 = '0;
      in_valid64 = 1'b0; x64 = '0; uns64 = 1'b0; tag64 = '0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_idle", idle, 1);
      checkOutput("rst_y", y, 0);
      checkOutput("rst_tag", tag_out, 0);
      checkOutput("rst_inexact", inexact, 0);
      checkOutput("rst_idle8", idle8, 1);
      checkOutput("rst_idle64", idle64, 1);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic stream");
      applyStimulus(32'h00000000, 1'b0, 5'd0, 32'h00000000, 1'b0);
      applyStimulus(32'h00000001, 1'b0, 5'd1, 32'h3F800000, 1'b0);
      applyStimulus(32'hFFFFFFFF, 1'b0, 5'd2, 32'hBF800000, 1'b0);
      drainAll("basic_drain");

      $display("[TB] rounding ties and extremes");
      applyStimulus(32'd16777217,  1'b0, 5'd3, 32'h4B800000, 1'b1);
      applyStimulus(32'd16777219,  1'b0, 5'd4, 32'h4B800002, 1'b1);
      applyStimulus(32'h7FFFFFFF,  1'b0, 5'd5, 32'h4F000000, 1'b1);
      applyStimulus(32'h80000000,  1'b0, 5'd6, 32'hCF000000, 1'b0);
      applyStimulus(32'h80000000,  1'b1, 5'd7, 32'h4F000000, 1'b0);
      applyStimulus(32'hFFFFFFFF,  1'b1, 5'd8, 32'h4F800000, 1'b1);
      drainAll("edge_drain");

      $display("[TB] back-pressure");
      base = n_results;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               xv = $urandom;
               refConvert(64'(xv), 32, 1'b0, ry, ri);
               applyStimulus(xv, 1'b0, 5'(10 + i), ry, ri);
            end
         end
         begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
               @(negedge clk);
               got = out_valid;
            end
            checkOutput("bp_first", got, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            checkOutput("bp_in_ready", in_ready, 0);
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drainAll("bp_drain");
      checkOutput("bp_count", n_results - base, 6);

      $display("[TB] reset mid-flight");
      base = n_results;
      for (int i = 0; i < 3; i++) begin
         xv = $urandom;
         refConvert(64'(xv), 32, 1'b0, ry, ri);
         applyStimulus(xv, 1'b0, 5'(20 + i), ry, ri);
      end
      @(posedge clk);
      #1;
      checkOutput("rst_pre_valid", out_valid, 1);
      rstn = 1'b0;
      #1;
      checkOutput("rst_mid_valid", out_valid, 0);
      checkOutput("rst_mid_idle", idle, 1);
      checkOutput("rst_mid_y", y, 0);
      exp_q.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("rst_no_stale", n_results - base, 0);
      checkOutput("rst_post_idle", idle, 1);

      $display("[TB] randomized stream");
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               case ($urandom_range(0, 4))
                  0: xv = $urandom;
                  1: xv = $urandom_range(0, 300);
                  2: xv = (32'h1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 2)) - 32'd1;
                  3: xv = (($urandom & 32'h01FFFFFF) | 32'h01000001) << $urandom_range(0, 7);
                  default: xv = corner[$urandom_range(0, 3)];
               endcase
               uns = 1'($urandom_range(0, 1));
               refConvert(64'(xv), 32, uns, ry, ri);
               applyStimulus(xv, uns, 5'($urandom), ry, ri);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drainAll("rand_drain");

      $display("[TB] width sweep");
      runSweep(8,  64'h80, 1'b0, 32'hC3000000, 1'b0, "w8_min");
      runSweep(64, 64'h8000000000000000, 1'b1, 32'h5F000000, 1'b0, "w64_top");
      runSweep(64, 64'h0020000000000001, 1'b0, 32'h5A000000, 1'b1, "w64_tie");
      for (int i = 0; i < 6; i++) begin
         xw  = 64'($urandom);
         uns = 1'($urandom_range(0, 1));
         refConvert(xw, 8, uns, ry, ri);
         runSweep(8, xw, uns, ry, ri, "w8_rand");
         xw  = {$urandom, $urandom} >> $urandom_range(0, 63);
         uns = 1'($urandom_range(0, 1));
         refConvert(xw, 64, uns, ry, ri);
         runSweep(64, xw, uns, ry, ri, "w64_rand");
      end
      checkOutput("end_idle", idle, 1);
      checkOutput("end_idle8", idle8, 1);
      checkOutput("end_idle64", idle64, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
